keypad_event_scanner: RTL and testbench
=======================================

# keypad_event_scanner

Front-end input stage of the O/X pattern-entry path. It drives the 4-row keypad scan and samples the 3 column inputs, A/B/C/D and submit buttons. It debounces everything on a per-scan-frame basis and emits exactly one 16-bit one-hot key event per physical press to the input-buffer stage over a valid/ready handshake. Bit order matches the combined flag word used downstream: bit[15:0] = [#,0,*,D,9,8,7,C,6,5,4,B,3,2,1,A].

## Interface
- SCAN_DIV, 250: clock cycles per row slot. Must be ≥ 4. The default gives a 5 µs slot and a 20 µs frame at 50 MHz.
- DEBOUNCE_FRAMES, 3: consecutive identical single-key frames required to accept a press. The same count of empty frames is required to accept a release.
- REPEAT_FRAMES, 25: autorepeat period in frames. Used only under the macro.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_from_keypad  in  3  column inputs. Exactly one of 100/010/001 means a key in the left/middle/right column. Any other value means no key.
- btn_a, btn_b, btn_c, btn_d  in  1 each  extra buttons, active-high, asynchronous.
- btn_submit  in  1  submit button, active-high, asynchronous.
- key_ready  in  1  downstream can accept an event.
- out_to_keypad  out  4  one-hot row drive.
- key_valid  out  1  event pending.
- key_onehot  out  16  event key, exactly one bit set while key_valid.
- key_code  out  4  binary index of the set bit.
- submit_pulse  out  1  one-cycle pulse per debounced submit press.
- overflow  out  1  sticky. Set when an event is dropped. Cleared only by rst.

## Operation
- All 8 asynchronous inputs (3 columns, 5 buttons) pass through 2-FF synchronisers.
- Row sequence is 0100 (1,2,3), then 0010 (4,5,6), then 0001 (7,8,9), then 1000 (*,0,#), then wraps. A slot counter of 0..SCAN_DIV-1 advances the row at its terminal count.
- At the last cycle of each slot, the synchronised columns are sampled into the frame vector bits for that row.
- Column mapping within a row is 100 = left, 010 = middle, 001 = right.
- Buttons A/B/C/D are sampled into bits 0/4/8/12 at the last cycle of slot 3.
- At frame end, the raw 16-bit vector is classified as empty, single (popcount 1), or multi. The frame vector then clears.
- Press FSM:
  - S_IDLE: a single frame captures the candidate, sets cnt=1 and moves to S_DEBOUNCE.
  - S_DEBOUNCE: a single frame equal to the candidate increments cnt. When cnt reaches DEBOUNCE_FRAMES, issue the event and move to S_HELD. An empty, multi, or different frame returns to S_IDLE.
  - S_HELD: an empty frame sets cnt=1 and moves to S_RELEASE. Any other frame stays in S_HELD; the same key held never re-issues.
  - S_RELEASE: an empty frame increments cnt, and reaching DEBOUNCE_FRAMES moves to S_IDLE. A non-empty frame returns to S_HELD.
- Event register:
  - Issuing while key_valid=0 loads key_onehot/key_code and sets key_valid.
  - Issuing while key_valid=1 drops the new event, sets overflow, and leaves the pending data unchanged.
  - key_valid clears on the cycle after key_valid & key_ready are both sampled high.
  - A new event issued in the same cycle as the handshake is loaded, not dropped.
- Submit uses an independent 2-state debouncer sampled at frame end. It fires submit_pulse after DEBOUNCE_FRAMES consecutive high frames and re-arms after DEBOUNCE_FRAMES consecutive low frames.
- Reset values:
  - out_to_keypad=0100 and slot counter=0.
  - key_valid=0, key_onehot=0, key_code=0.
  - submit_pulse=0, overflow=0.
  - FSMs in idle and frame vector=0.
- Reset mid-debounce discards all progress.

## Timing
- Frame length is 4·SCAN_DIV cycles.
- Press latency from first full stable frame to key_valid is DEBOUNCE_FRAMES frames plus 1 cycle, plus the 2-cycle synchroniser delay on sampled inputs.
- A key must be presented through ≥ DEBOUNCE_FRAMES complete frames to be accepted.
- key_valid/key_onehot are registered and stable until the handshake.
- submit_pulse is exactly one cycle, asserted 1 cycle after frame end.
- out_to_keypad changes 1 cycle after the slot terminal count.

## Configuration
- KEYSCAN_AUTOREPEAT_EN defined: in S_HELD, the same single key held for REPEAT_FRAMES further frames re-issues the event, and repeats every REPEAT_FRAMES frames. Autorepeat never applies to submit.
- KEYSCAN_AUTOREPEAT_EN undefined: strictly one event per press. The REPEAT_FRAMES counter is not built.

## Structure
- keyscan_pkg holds:
  - key bit-index constants (KEY_A=0 … KEY_HASH=15);
  - row one-hot constants (ROW_123, ROW_456, ROW_789, ROW_STAR);
  - the press FSM state enum (S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE).
- One sub-module, keyscan_sync: parameterised-width 2-FF synchroniser with asynchronous reset to 0. It is instantiated for columns (reset 111 via inversion at the port) and for buttons.

## Test plan
Bench settings: SCAN_DIV=8, DEBOUNCE_FRAMES=3, key_ready=1 unless stated. Columns are driven only while the target row is active.
- Key 5 (row 0010, col 010) held 10 frames → exactly one key_valid, key_onehot=16'h0040, key_code=6, no event after release.
- btn_a held 2 frames → no event. btn_a held 5 frames → key_onehot=16'h0001, key_code=0.
- Keys 1 and 9 held together 10 frames → no event. Release, then # held 5 frames → key_onehot=16'h8000, key_code=15.
- key_ready=0, key 2 pressed then key 3 pressed → key_onehot stays 16'h0004, overflow=1. Raise key_ready → key_valid low the following cycle.
- rst pulsed during S_DEBOUNCE of key 7 → out_to_keypad=0100, key_valid=0, no event. Key 7 re-pressed 5 frames → key_onehot=16'h0200.
- btn_submit held 10 frames → exactly one submit_pulse and no key event. Under KEYSCAN_AUTOREPEAT_EN, key 0 held 60 frames with REPEAT_FRAMES=25 → 3 events of 16'h4000.

Source files
------------

// File: rtl/keyscan_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keyscan_pkg                                                              |
// | Shared key bit indices, row drive codes and press-FSM states for the     |
// | keypad event scanner.                                                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package keyscan_pkg;

    // Bit positions in the 16-bit flag word [#,0,*,D,9,8,7,C,6,5,4,B,3,2,1,A]
    localparam int KEY_A    = 0;
    localparam int KEY_1    = 1;
    localparam int KEY_2    = 2;
    localparam int KEY_3    = 3;
    localparam int KEY_B    = 4;
    localparam int KEY_4    = 5;
    localparam int KEY_5    = 6;
    localparam int KEY_6    = 7;
    localparam int KEY_C    = 8;
    localparam int KEY_7    = 9;
    localparam int KEY_8    = 10;
    localparam int KEY_9    = 11;
    localparam int KEY_D    = 12;
    localparam int KEY_STAR = 13;
    localparam int KEY_0    = 14;
    localparam int KEY_HASH = 15;

    localparam logic [3:0] ROW_123  = 4'b0100;
    localparam logic [3:0] ROW_456  = 4'b0010;
    localparam logic [3:0] ROW_789  = 4'b0001;
    localparam logic [3:0] ROW_STAR = 4'b1000;

    typedef logic [1:0] press_state_t;

    localparam press_state_t S_IDLE     = 2'd0;
    localparam press_state_t S_DEBOUNCE = 2'd1;
    localparam press_state_t S_HELD     = 2'd2;
    localparam press_state_t S_RELEASE  = 2'd3;

    function automatic logic [3:0] onehot_to_code(input logic [15:0] v);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) code = code | 4'(i);
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keyscan_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keyscan_sync                                                             |
// | Parameterised-width two-flop synchroniser, asynchronous reset to zero.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module keyscan_sync
    import keyscan_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_event_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_event_scanner                                                     |
// | Scans a 4x3 keypad plus A/B/C/D/submit buttons, debounces per frame and  |
// | emits one one-hot key event per press over valid/ready.                  |
// | Optional autorepeat: define KEYSCAN_AUTOREPEAT_EN.                       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module keypad_event_scanner
    import keyscan_pkg::*;
#(
    parameter int SCAN_DIV        = 250,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int REPEAT_FRAMES   = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  in_from_keypad,
    input  logic        btn_a,
    input  logic        btn_b,
    input  logic        btn_c,
    input  logic        btn_d,
    input  logic        btn_submit,
    input  logic        key_ready,
    output logic [3:0]  out_to_keypad,
    output logic        key_valid,
    output logic [15:0] key_onehot,
    output logic [3:0]  key_code,
    output logic        submit_pulse,
    output logic        overflow
);

    localparam int                  c_slot_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(SCAN_DIV - 1);
    localparam int                  c_cnt_w     = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [c_cnt_w-1:0]  c_deb       = c_cnt_w'(DEBOUNCE_FRAMES);
    localparam logic [c_cnt_w-1:0]  c_one       = c_cnt_w'(1);
    localparam logic [0:0]          c_sub_armed = 1'b0;
    localparam logic [0:0]          c_sub_fired = 1'b1;
`ifdef KEYSCAN_AUTOREPEAT_EN
    localparam int                  c_rep_w     = $clog2(REPEAT_FRAMES + 1);
    localparam logic [c_rep_w-1:0]  c_rep       = c_rep_w'(REPEAT_FRAMES);
`endif

    logic [2:0]          w_col_n;
    logic [2:0]          w_col;
    logic [2:0]          w_col_bits;
    logic [4:0]          w_btn;
    logic [c_slot_w-1:0] r_slot;
    logic [3:0]          r_row;
    logic                w_slot_end;
    logic                w_frame_end;
    logic [15:0]         r_frame;
    logic [15:0]         w_frame;
    logic                w_empty;
    logic                w_single;
    press_state_t        r_state;
    press_state_t        w_state_nx;
    logic [15:0]         r_cand;
    logic [15:0]         w_cand_nx;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nx;
    logic [c_cnt_w-1:0]  w_cnt_inc;
    logic                w_issue;
    logic                w_handshake;
    logic                r_valid;
    logic [15:0]         r_onehot;
    logic [3:0]          r_code;
    logic                r_ovf;
    logic [0:0]          r_sub_state;
    logic [c_cnt_w-1:0]  r_sub_cnt;
    logic [c_cnt_w-1:0]  w_sub_inc;
    logic                r_sub_pulse;
`ifdef KEYSCAN_AUTOREPEAT_EN
    logic [c_rep_w-1:0]  r_rep;
    logic [c_rep_w-1:0]  w_rep_nx;
    logic [c_rep_w-1:0]  w_rep_inc;
`endif

    // Columns idle at 111 ("no key") out of reset: synchronise the inverse.
    keyscan_sync #(.WIDTH(3)) u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (~in_from_keypad),
        .q   (w_col_n)
    );
    assign w_col = ~w_col_n;

    keyscan_sync #(.WIDTH(5)) u_btn_sync (
        .clk (clk),
        .rst (rst),
        .d   ({btn_submit, btn_d, btn_c, btn_b, btn_a}),
        .q   (w_btn)
    );

    assign w_slot_end  = (r_slot == c_slot_last);
    assign w_frame_end = w_slot_end && (r_row == ROW_STAR);
    // Left column (100) lands on the lowest bit of the row's three-key group.
    assign w_col_bits  = $onehot(w_col) ? {w_col[0], w_col[1], w_col[2]} : 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
            r_row  <= ROW_123;
        end else if (w_slot_end) begin
            r_slot <= '0;
            case (r_row)
                ROW_123: r_row <= ROW_456;
                ROW_456: r_row <= ROW_789;
                ROW_789: r_row <= ROW_STAR;
                default: r_row <= ROW_123;
            endcase
        end else begin
            r_slot <= r_slot + 1'b1;
        end
    end

    always_comb begin
        w_frame = r_frame;
        if (w_slot_end) begin
            case (r_row)
                ROW_123: w_frame[KEY_1 +: 3] = w_col_bits;
                ROW_456: w_frame[KEY_4 +: 3] = w_col_bits;
                ROW_789: w_frame[KEY_7 +: 3] = w_col_bits;
                ROW_STAR: begin
                    w_frame[KEY_STAR +: 3] = w_col_bits;
                    w_frame[KEY_A]         = w_btn[0];
                    w_frame[KEY_B]         = w_btn[1];
                    w_frame[KEY_C]         = w_btn[2];
                    w_frame[KEY_D]         = w_btn[3];
                end
                default: w_frame = r_frame;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame <= '0;
        end else if (w_frame_end) begin
            r_frame <= '0;
        end else begin
            r_frame <= w_frame;
        end
    end

    assign w_empty   = (w_frame == 16'h0000);
    assign w_single  = $onehot(w_frame);
    assign w_cnt_inc = r_cnt + 1'b1;
`ifdef KEYSCAN_AUTOREPEAT_EN
    assign w_rep_inc = r_rep + 1'b1;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_cand_nx  = r_cand;
        w_cnt_nx   = r_cnt;
        w_issue    = 1'b0;
`ifdef KEYSCAN_AUTOREPEAT_EN
        // Any frame that is not a continued hold of the same key restarts the period.
        w_rep_nx   = w_frame_end ? '0 : r_rep;
`endif
        if (w_frame_end) begin
            case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        w_cand_nx = w_frame;
                        w_cnt_nx  = c_one;
                        if (c_deb == c_one) begin
                            w_issue    = 1'b1;
                            w_state_nx = S_HELD;
                        end else begin
                            w_state_nx = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (w_single && (w_frame == r_cand)) begin
                        w_cnt_nx = w_cnt_inc;
                        if (w_cnt_inc == c_deb) begin
                            w_issue    = 1'b1;
                            w_state_nx = S_HELD;
                        end
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (w_empty) begin
                        w_cnt_nx   = c_one;
                        w_state_nx = (c_deb == c_one) ? S_IDLE : S_RELEASE;
                    end
`ifdef KEYSCAN_AUTOREPEAT_EN
                    else if (w_frame == r_cand) begin
                        if (w_rep_inc == c_rep) begin
                            w_issue  = 1'b1;
                            w_rep_nx = '0;
                        end else begin
                            w_rep_nx = w_rep_inc;
                        end
                    end
`endif
                end
                S_RELEASE: begin
                    if (w_empty) begin
                        w_cnt_nx = w_cnt_inc;
                        if (w_cnt_inc == c_deb) w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = S_HELD;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
`ifdef KEYSCAN_AUTOREPEAT_EN
            r_rep   <= '0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_cand  <= w_cand_nx;
            r_cnt   <= w_cnt_nx;
`ifdef KEYSCAN_AUTOREPEAT_EN
            r_rep   <= w_rep_nx;
`endif
        end
    end

    // A slot freed by this cycle's handshake can take a new event immediately.
    assign w_handshake = r_valid & key_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_onehot <= '0;
            r_code   <= '0;
            r_ovf    <= 1'b0;
        end else if (w_issue && (!r_valid || w_handshake)) begin
            r_valid  <= 1'b1;
            r_onehot <= w_cand_nx;
            r_code   <= onehot_to_code(w_cand_nx);
        end else begin
            if (w_issue)     r_ovf   <= 1'b1;
            if (w_handshake) r_valid <= 1'b0;
        end
    end

    assign w_sub_inc = r_sub_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sub_state <= c_sub_armed;
            r_sub_cnt   <= '0;
            r_sub_pulse <= 1'b0;
        end else begin
            r_sub_pulse <= 1'b0;
            if (w_frame_end) begin
                if (r_sub_state == c_sub_armed) begin
                    if (!w_btn[4]) begin
                        r_sub_cnt <= '0;
                    end else if (w_sub_inc == c_deb) begin
                        r_sub_pulse <= 1'b1;
                        r_sub_state <= c_sub_fired;
                        r_sub_cnt   <= '0;
                    end else begin
                        r_sub_cnt <= w_sub_inc;
                    end
                end else begin
                    if (w_btn[4]) begin
                        r_sub_cnt <= '0;
                    end else if (w_sub_inc == c_deb) begin
                        r_sub_state <= c_sub_armed;
                        r_sub_cnt   <= '0;
                    end else begin
                        r_sub_cnt <= w_sub_inc;
                    end
                end
            end
        end
    end

    assign out_to_keypad = r_row;
    assign key_valid     = r_valid;
    assign key_onehot    = r_onehot;
    assign key_code      = r_code;
    assign submit_pulse  = r_sub_pulse;
    assign overflow      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_keypad_event_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_keypad_event_scanner                                                  |
// | Frame-level keypad model with a behavioural reference and a table of     |
// | directed press scenarios, plus randomized frames.                        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_keypad_event_scanner;

    localparam int SD  = 8;
    localparam int DEB = 3;
    localparam int REP = 25;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_from_keypad;
    logic        btn_a, btn_b, btn_c, btn_d, btn_submit;
    logic        key_ready;
    logic [3:0]  out_to_keypad;
    logic        key_valid;
    logic [15:0] key_onehot;
    logic [3:0]  key_code;
    logic        submit_pulse;
    logic        overflow;

    logic [15:0] held;
    logic        sub_held;

    int n_vec = 0;
    int n_err = 0;

    keypad_event_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_FRAMES (DEB),
        .REPEAT_FRAMES   (REP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_from_keypad (in_from_keypad),
        .btn_a          (btn_a),
        .btn_b          (btn_b),
        .btn_c          (btn_c),
        .btn_d          (btn_d),
        .btn_submit     (btn_submit),
        .key_ready      (key_ready),
        .out_to_keypad  (out_to_keypad),
        .key_valid      (key_valid),
        .key_onehot     (key_onehot),
        .key_code       (key_code),
        .submit_pulse   (submit_pulse),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // Physical keypad: a held key connects its column only while its row is driven.
    always_comb begin
        in_from_keypad = 3'b000;
        for (int r = 0; r < 4; r++) begin
            if (out_to_keypad == row_code(r))
                in_from_keypad = {held[4*r+1], held[4*r+2], held[4*r+3]};
        end
    end
    assign btn_a      = held[0];
    assign btn_b      = held[4];
    assign btn_c      = held[8];
    assign btn_d      = held[12];
    assign btn_submit = sub_held;

    function automatic logic [3:0] row_code(input int r);
        case (r)
            0:       return 4'b0100;
            1:       return 4'b0010;
            2:       return 4'b0001;
            default: return 4'b1000;
        endcase
    endfunction

    // Frame word seen for a set of held keys: a row with two keys pressed reads as no key.
    function automatic logic [15:0] frame_of(input logic [15:0] h);
        logic [15:0] f;
        f = h & 16'h1111;
        for (int r = 0; r < 4; r++) begin
            if ($countones(h[4*r+1 +: 3]) == 1) f[4*r+1 +: 3] = h[4*r+1 +: 3];
        end
        return f;
    endfunction

    function automatic int idx_of(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Reference model state
    logic        m_held;
    int          m_run, m_erun, m_rep;
    logic [15:0] m_cand;
    logic        m_valid, m_ovf, m_pulse;
    logic [15:0] m_key;
    logic        m_sfired;
    int          m_srun;

    task automatic model_reset();
        m_held = 0; m_run = 0; m_erun = 0; m_rep = 0; m_cand = '0;
        m_valid = 0; m_ovf = 0; m_pulse = 0; m_key = '0;
        m_sfired = 0; m_srun = 0;
    endtask

    task automatic model_step(input logic [15:0] f, input logic s);
        logic issue;
        logic single;
        issue  = 0;
        single = ($countones(f) == 1);
        if (!m_held) begin
            if (m_run == 0) begin
                if (single) begin m_cand = f; m_run = 1; end
            end else if (single && f == m_cand) begin
                m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run >= DEB) begin
                issue = 1; m_held = 1; m_run = 0; m_erun = 0; m_rep = 0;
            end
        end else if (f == 16'h0) begin
            m_erun++; m_rep = 0;
            if (m_erun >= DEB) begin m_held = 0; m_erun = 0; end
        end else begin
            if (m_erun == 0 && f == m_cand) m_rep++;
            else m_rep = 0;
            m_erun = 0;
`ifdef KEYSCAN_AUTOREPEAT_EN
            if (m_rep >= REP) begin issue = 1; m_rep = 0; end
`endif
        end
        if (issue) begin
            if (m_valid) m_ovf = 1;
            else begin m_valid = 1; m_key = m_cand; end
        end
        m_pulse = 0;
        if (!m_sfired) begin
            if (s) begin
                m_srun++;
                if (m_srun >= DEB) begin m_pulse = 1; m_sfired = 1; m_srun = 0; end
            end else m_srun = 0;
        end else begin
            if (!s) begin
                m_srun++;
                if (m_srun >= DEB) begin m_sfired = 0; m_srun = 0; end
            end else m_srun = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    int          ev_cnt, sub_cnt;
    logic [15:0] last_key;
    logic [3:0]  last_code;

    // Called at the first negedge of a frame; returns at the first negedge of the next.
    task automatic run_frame(input logic [15:0] pat, input logic s);
        held = pat;
        sub_held = s;
        repeat (4*SD) @(negedge clk);
        model_step(frame_of(pat), s);
        check("key_valid", key_valid, m_valid);
        if (m_valid) begin
            check("key_onehot", key_onehot, m_key);
            check("key_code", key_code, idx_of(m_key));
        end
        check("submit_pulse", submit_pulse, m_pulse);
        check("overflow", overflow, m_ovf);
        if (key_valid && key_ready) begin
            ev_cnt++; last_key = key_onehot; last_code = key_code;
        end
        if (submit_pulse) sub_cnt++;
        if (key_ready) m_valid = 0;
    endtask

    task automatic sync_frame();
        logic [3:0] prev;
        int guard;
        guard = 0;
        prev = out_to_keypad;
        @(negedge clk);
        while (!(prev == 4'b1000 && out_to_keypad == 4'b0100)) begin
            prev = out_to_keypad;
            @(negedge clk);
            guard++;
            if (guard > 16*SD) begin
                n_vec++; n_err++;
                $display("FAIL frame_sync: got no frame boundary, expected one within %0d cycles", 16*SD);
                return;
            end
        end
    endtask

    typedef struct {
        logic [15:0] pat;
        logic        sub;
        int          frames;
        int          exp_events;
        logic [15:0] exp_key;
        logic [3:0]  exp_code;
        int          exp_subs;
    } vec_t;

    vec_t        tbl[14];
    logic [15:0] rpat;
    logic        rsub;
    int          c;

    initial begin
        tbl[0]  = '{16'h0040, 1'b0, 10, 1, 16'h0040, 4'd6,  0};  // key 5
        tbl[1]  = '{16'h0000, 1'b0,  4, 0, 16'h0000, 4'd0,  0};
        tbl[2]  = '{16'h0001, 1'b0,  2, 0, 16'h0000, 4'd0,  0};  // A too short
        tbl[3]  = '{16'h0000, 1'b0,  4, 0, 16'h0000, 4'd0,  0};
        tbl[4]  = '{16'h0001, 1'b0,  5, 1, 16'h0001, 4'd0,  0};  // A accepted
        tbl[5]  = '{16'h0000, 1'b0,  4, 0, 16'h0000, 4'd0,  0};
        tbl[6]  = '{16'h0802, 1'b0, 10, 0, 16'h0000, 4'd0,  0};  // 1 and 9
        tbl[7]  = '{16'h0000, 1'b0,  4, 0, 16'h0000, 4'd0,  0};
        tbl[8]  = '{16'h8000, 1'b0,  5, 1, 16'h8000, 4'd15, 0};  // #
        tbl[9]  = '{16'h0000, 1'b0,  4, 0, 16'h0000, 4'd0,  0};
        tbl[10] = '{16'h0000, 1'b1, 10, 0, 16'h0000, 4'd0,  1};  // submit
        tbl[11] = '{16'h0000, 1'b0,  4, 0, 16'h0000, 4'd0,  0};
        tbl[12] = '{16'h0006, 1'b0,  5, 0, 16'h0000, 4'd0,  0};  // 1 and 2, same row
        tbl[13] = '{16'h0000, 1'b0,  4, 0, 16'h0000, 4'd0,  0};

        rst = 1'b1; held = '0; sub_held = 1'b0; key_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_row", out_to_keypad, 4'b0100);
        check("rst_valid", key_valid, 1'b0);
        check("rst_onehot", key_onehot, 16'h0000);
        check("rst_code", key_code, 4'd0);
        check("rst_submit", submit_pulse, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        sync_frame();

        for (int i = 0; i < 14; i++) begin
            ev_cnt = 0; sub_cnt = 0; last_key = '0; last_code = '0;
            for (int k = 0; k < tbl[i].frames; k++) run_frame(tbl[i].pat, tbl[i].sub);
            check($sformatf("tbl%0d_events", i), ev_cnt, tbl[i].exp_events);
            if (tbl[i].exp_events > 0) begin
                check($sformatf("tbl%0d_key", i), last_key, tbl[i].exp_key);
                check($sformatf("tbl%0d_code", i), last_code, tbl[i].exp_code);
            end
            check($sformatf("tbl%0d_submits", i), sub_cnt, tbl[i].exp_subs);
        end

        // Backpressure: second press is dropped and flagged.
        key_ready = 1'b0;
        for (int k = 0; k < 4; k++) run_frame(16'h0004, 1'b0);
        for (int k = 0; k < 4; k++) run_frame(16'h0000, 1'b0);
        for (int k = 0; k < 4; k++) run_frame(16'h0008, 1'b0);
        check("ovf_key", key_onehot, 16'h0004);
        check("ovf_flag", overflow, 1'b1);
        key_ready = 1'b1;
        @(negedge clk);
        check("ovf_drain_valid", key_valid, 1'b0);
        m_valid = 0;
        repeat (4*SD - 1) @(negedge clk);
        for (int k = 0; k < 4; k++) run_frame(16'h0000, 1'b0);

        // Reset in the middle of debouncing key 7.
        ev_cnt = 0;
        for (int k = 0; k < 2; k++) run_frame(16'h0200, 1'b0);
        repeat (2*SD) @(negedge clk);
        rst = 1'b1; held = '0;
        #1;
        check("midrst_row", out_to_keypad, 4'b0100);
        check("midrst_valid", key_valid, 1'b0);
        check("midrst_overflow", overflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        sync_frame();
        for (int k = 0; k < 3; k++) run_frame(16'h0000, 1'b0);
        check("midrst_no_event", ev_cnt, 0);
        for (int k = 0; k < 5; k++) run_frame(16'h0200, 1'b0);
        check("midrst_events", ev_cnt, 1);
        check("midrst_key", last_key, 16'h0200);

        // Randomized frames against the reference model.
        rpat = '0; rsub = 1'b0;
        for (int f = 0; f < 200; f++) begin
            c = $urandom_range(0, 99);
            if (c < 60)      rpat = rpat;
            else if (c < 75) rpat = '0;
            else if (c < 92) rpat = 16'h1 << $urandom_range(0, 15);
            else             rpat = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            if ($urandom_range(0, 9) < 2) rsub = ~rsub;
            run_frame(rpat, rsub);
        end
        for (int k = 0; k < 4; k++) run_frame(16'h0000, 1'b0);

`ifdef KEYSCAN_AUTOREPEAT_EN
        ev_cnt = 0;
        for (int k = 0; k < 60; k++) run_frame(16'h4000, 1'b0);
        check("repeat_events", ev_cnt, 3);
        check("repeat_key", last_key, 16'h4000);
        for (int k = 0; k < 4; k++) run_frame(16'h0000, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
